width_upsizer: RTL
==================

Name: width_upsizer

Overview:
- Parametrised successor to the width-doubling adapter.
- Packs RATIO narrow input beats into one wide output word in a single stage, so cascaded 2x stages are no longer needed (e.g. 16->128 in one block).
- Adds ready/valid backpressure on both sides, plus a partial-word flush on din_last with a lane-count output.
- Sits between narrow stream producers (ADC/serial front-ends) and wide datapath or memory-write logic.

Parameters:
- WIDTH_DIN, 16, input lane width in bits (>=1).
- RATIO, 8, input beats per output word (>=2; need not be a power of two).
- ZERO_PAD, 1, 1 = unused lanes of a partial word are driven 0; 0 = unused lanes keep stale accumulator contents.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_vld  in  1  input beat valid.
- din_rdy  out  1  block can accept a beat.
- din  in  WIDTH_DIN  input data.
- din_last  in  1  final beat of a packet; qualified by din_vld.
- dout_vld  out  1  output word valid.
- dout_rdy  in  1  downstream accepts the word.
- dout  out  WIDTH_DIN*RATIO  packed word; first-received beat in lane 0 (LSBs).
- dout_last  out  1  word closes a packet.
- dout_cnt  out  $clog2(RATIO+1)  number of valid lanes in dout (1..RATIO).

Behaviour:
- Reset: dout_vld=0, dout_last=0, dout_cnt=0, dout=0, lane index idx=0, state=FILL, accumulator cleared. din_rdy is 0 while rst is high.
- Handshake: in_xfer = din_vld & din_rdy; out_xfer = dout_vld & dout_rdy.
- Output register: dout, dout_last and dout_cnt hold stable while dout_vld=1 and dout_rdy=0.
- out_free = !dout_vld | dout_rdy.
- FILL state:
  - din_rdy = (idx < RATIO-1) | out_free. A beat that completes a word is accepted only if the output slot is free this cycle.
  - On in_xfer, din is written to lane idx.
  - If idx==RATIO-1: the word moves to the output register on the same edge; dout_vld=1, dout_cnt=RATIO, dout_last=din_last, idx=0.
  - Else if din_last and out_free: the partial word moves to the output register; dout_cnt=idx+1, dout_last=1, idx=0.
  - Else if din_last and !out_free: the beat is stored, cnt_pend=idx+1, state goes to FLUSH_WAIT.
  - Else: idx increments.
- FLUSH_WAIT state:
  - din_rdy=0.
  - When out_free, the accumulator moves to the output register with dout_cnt=cnt_pend and dout_last=1; idx=0; state returns to FILL.
- Latency: one cycle from the completing in_xfer to dout_vld=1 when the output is free.
- Throughput: one input beat per cycle sustained when dout_rdy=1.
- Transferring a word clears dout_vld only if out_xfer occurs and no new word loads on the same edge. Load and unload on the same edge is allowed and keeps dout_vld=1.
- ZERO_PAD=1: lanes >= dout_cnt are 0 in the output word.
- din_last on the RATIO-th beat gives a full word with dout_last=1 and dout_cnt=RATIO.
- A single-beat packet (din_last with idx=0) gives dout_cnt=1.
- din_last has no effect unless in_xfer.
- Asserting rst mid-packet discards the partial accumulator and any held output word.
- dout_cnt is 0 only when dout_vld=0.

Decomposition:
- Package width_upsizer_pkg: state encoding (FILL, FLUSH_WAIT) and the function for the count width, clog2(RATIO+1).
- One natural sub-module: upsizer_out_reg, the output register slot with load/unload/hold logic and out_free generation. The lane accumulator and control stay in the top module.

Test Plan:
- WIDTH_DIN=16, RATIO=8, dout_rdy=1: 16 beats 0x0001..0x0010 back-to-back, din_last on beat 16 -> two words. Word 1 = 0x0008_0007_..._0001, cnt=8, last=0. Word 2 lanes 0x0009..0x0010, cnt=8, last=1. Each word appears one cycle after its 8th beat; din_rdy stays 1.
- RATIO=8, 3 beats 0xAAAA, 0xBBBB, 0xCCCC with last on 3rd -> dout = 0x...0000_CCCC_BBBB_AAAA (upper 5 lanes 0), cnt=3, last=1.
- Hold dout_rdy=0 with a full word pending, then send 7 beats -> all 7 accepted; 8th beat sees din_rdy=0 until dout_rdy=1, then is accepted on that same cycle. No data lost or duplicated.
- dout_rdy=0 with a word pending; send beat 0x1234 with last at idx=2 -> FLUSH_WAIT, din_rdy=0. On dout_rdy=1 the pending word drains, then the next word has cnt=3, last=1, and din_rdy returns to 1.
- Random din_vld at 20% and dout_rdy at 50%, packets of lengths 1..40 with RATIO=5 -> scoreboard matches all lanes, cnt=((len-1)%5)+1 on last words, and dout stays stable while stalled.
- Assert rst mid-packet after 4 beats -> dout_vld=0 immediately. The next 8 beats form a clean word with cnt=8 and no residue from before the reset.

Source files
------------

// File: rtl/width_upsizer_pkg.sv
// Shared types and sizing helpers for the width upsizer.
package width_upsizer_pkg;

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  // Width needed to hold a lane count of 0..ratio.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Width needed to address lanes 0..ratio-1.
  function automatic int idx_width(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/upsizer_out_reg.sv
// Single output word slot: loads a packed word, holds it under backpressure,
// and frees itself once the downstream accepts it.
module upsizer_out_reg #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              word_last,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic              dout_rdy,
  output logic              dout_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_last,
  output logic [CNT_W-1:0]  dout_cnt,
  output logic              out_free
);

  // The slot can take a new word when empty or when it empties on this edge.
  assign out_free = !dout_vld || dout_rdy;

  // Load has priority over unload so a same-edge swap keeps dout_vld high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_vld  <= 1'b0;
      dout      <= '0;
      dout_last <= 1'b0;
      dout_cnt  <= '0;
    end else if (load) begin
      dout_vld  <= 1'b1;
      dout      <= word;
      dout_last <= word_last;
      dout_cnt  <= word_cnt;
    end else if (dout_rdy) begin
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      dout_cnt  <= '0;
    end
  end

endmodule

// File: rtl/width_upsizer.sv
// Packs RATIO narrow beats into one wide word, with ready/valid on both sides
// and early flush of a partial word when din_last arrives.
module width_upsizer
  import width_upsizer_pkg::*;
#(
  parameter int WIDTH_DIN = 16,
  parameter int RATIO     = 8,
  parameter int ZERO_PAD  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_vld,
  output logic                           din_rdy,
  input  logic [WIDTH_DIN-1:0]           din,
  input  logic                           din_last,
  output logic                           dout_vld,
  input  logic                           dout_rdy,
  output logic [WIDTH_DIN*RATIO-1:0]     dout,
  output logic                           dout_last,
  output logic [cnt_width(RATIO)-1:0]    dout_cnt
);

  localparam int CNT_W  = cnt_width(RATIO);
  localparam int IDX_W  = idx_width(RATIO);
  localparam int WORD_W = WIDTH_DIN * RATIO;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt_pend;
  logic [WIDTH_DIN-1:0] acc [RATIO];

  logic                 out_free;
  logic                 in_xfer;
  logic                 at_last_lane;
  logic                 load;
  logic                 load_last;
  logic [CNT_W-1:0]     load_cnt;
  logic [WORD_W-1:0]    load_word;

  // A beat that completes a word needs the output slot free on the same edge.
  assign at_last_lane = (idx == IDX_LAST);
  assign din_rdy      = !rst && (state == FILL) && (!at_last_lane || out_free);
  assign in_xfer      = din_vld && din_rdy;

  // Decide whether a word moves to the output slot this edge, and its tags.
  always_comb begin
    load      = 1'b0;
    load_last = 1'b1;
    load_cnt  = cnt_pend;
    if (state == FLUSH_WAIT) begin
      load = out_free;
    end else if (in_xfer) begin
      if (at_last_lane) begin
        load      = 1'b1;
        load_last = din_last;
        load_cnt  = CNT_FULL;
      end else if (din_last && out_free) begin
        load     = 1'b1;
        load_cnt = CNT_W'(idx) + CNT_W'(1);
      end
    end
  end

  // Assemble the outgoing word: the current beat bypasses into its lane while
  // filling, and lanes past the count are blanked when padding is enabled.
  always_comb begin
    load_word = '0;
    for (int l = 0; l < RATIO; l++) begin
      load_word[l*WIDTH_DIN +: WIDTH_DIN] =
        (state == FILL && idx == IDX_W'(l)) ? din : acc[l];
      if (ZERO_PAD != 0 && CNT_W'(l) >= load_cnt) begin
        load_word[l*WIDTH_DIN +: WIDTH_DIN] = '0;
      end
    end
  end

  // Lane accumulator: each accepted beat lands in the lane at idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < RATIO; l++) acc[l] <= '0;
    end else if (in_xfer) begin
      for (int l = 0; l < RATIO; l++) begin
        if (idx == IDX_W'(l)) acc[l] <= din;
      end
    end
  end

  // Fill/flush control: lane index, pending partial count and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      idx      <= '0;
      cnt_pend <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            if (at_last_lane || (din_last && out_free)) begin
              idx <= '0;
            end else if (din_last) begin
              cnt_pend <= CNT_W'(idx) + CNT_W'(1);
              state    <= FLUSH_WAIT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FLUSH_WAIT: begin
          if (out_free) begin
            idx   <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  upsizer_out_reg #(
    .DATA_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (load_word),
    .word_last (load_last),
    .word_cnt  (load_cnt),
    .dout_rdy  (dout_rdy),
    .dout_vld  (dout_vld),
    .dout      (dout),
    .dout_last (dout_last),
    .dout_cnt  (dout_cnt),
    .out_free  (out_free)
  );

endmodule
